// File: rtl/divider_pkg.sv
// Shared encodings for the iterative RV32M divide/remainder unit.
// Holds the op codes, FSM states, iteration count and a two's-complement magnitude helper.
package divider_pkg;

  localparam int DIV_XLEN   = 32;
  localparam int ITER_COUNT = 32;

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } div_state_t;

  // Magnitude of a signed word; 0x80000000 maps to itself, read as unsigned 2^31.
  function automatic logic [DIV_XLEN-1:0] abs_val(input logic [DIV_XLEN-1:0] x);
    if (x[DIV_XLEN-1]) begin
      return ~x + 32'd1;
    end else begin
      return x;
    end
  endfunction

endpackage

// File: rtl/iter_divider_step.sv
// One combinational radix-2 restoring division iteration over {R,Q}.
// Kept separate so two copies can be chained for a radix-4 datapath.
module iter_divider_step
  import divider_pkg::*;
(
  input  logic [DIV_XLEN:0]   rem_in,
  input  logic [DIV_XLEN-1:0] quo_in,
  input  logic [DIV_XLEN-1:0] divisor,
  output logic [DIV_XLEN:0]   rem_out,
  output logic [DIV_XLEN-1:0] quo_out
);

  logic [DIV_XLEN+1:0] shifted_s;
  logic [DIV_XLEN+1:0] diff_s;

  // Shift in the next dividend bit and subtract; restore when the trial goes negative.
  always_comb begin
    shifted_s = {rem_in, quo_in[DIV_XLEN-1]};
    diff_s    = shifted_s - {2'b00, divisor};
    if (!diff_s[DIV_XLEN+1]) begin
      rem_out = diff_s[DIV_XLEN:0];
      quo_out = {quo_in[DIV_XLEN-2:0], 1'b1};
    end else begin
      rem_out = shifted_s[DIV_XLEN:0];
      quo_out = {quo_in[DIV_XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/iter_divider.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU unit, one quotient bit per cycle,
// with valid/ready handshakes on both sides and single-cycle fast paths.
module iter_divider
  import divider_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      div_op,
  input  logic [XLEN-1:0] a_data,
  input  logic [XLEN-1:0] b_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] div_res
);

  div_state_t      state_r;
  logic [5:0]      count_r;
  logic [XLEN:0]   rem_r;
  logic [XLEN-1:0] quo_r;
  logic [XLEN-1:0] divisor_r;
  logic            quo_neg_r;
  logic            rem_neg_r;
  logic [1:0]      op_r;
  logic [XLEN-1:0] res_r;
  logic            in_ready_r;
  logic            out_valid_r;

  logic            signed_op_s;
  logic [XLEN-1:0] abs_a_s;
  logic [XLEN-1:0] abs_b_s;
  logic            div_zero_s;
  logic            overflow_s;
  logic [XLEN:0]   rem_next_s;
  logic [XLEN-1:0] quo_next_s;
  logic [XLEN:0]   rem_fix_s;
  logic [XLEN-1:0] quo_fix_s;

  // Operand decode at acceptance: magnitudes and the two fast-path conditions.
  always_comb begin
    signed_op_s = ~div_op[0];
    div_zero_s  = (b_data == 32'd0);
    if (signed_op_s) begin
      abs_a_s    = abs_val(a_data);
      abs_b_s    = abs_val(b_data);
      overflow_s = (a_data == 32'h8000_0000) && (b_data == 32'hFFFF_FFFF);
    end else begin
      abs_a_s    = a_data;
      abs_b_s    = b_data;
      overflow_s = 1'b0;
    end
  end

  iter_divider_step u_step (
    .rem_in  (rem_r),
    .quo_in  (quo_r),
    .divisor (divisor_r),
    .rem_out (rem_next_s),
    .quo_out (quo_next_s)
  );

  // Sign correction of the unsigned result for signed ops.
  always_comb begin
    if (quo_neg_r) begin
      quo_fix_s = ~quo_r + 32'd1;
    end else begin
      quo_fix_s = quo_r;
    end
    if (rem_neg_r) begin
      rem_fix_s = ~rem_r + 33'd1;
    end else begin
      rem_fix_s = rem_r;
    end
  end

  // Control FSM and datapath registers; reset beats flush, flush beats handshakes.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      count_r     <= 6'd0;
      rem_r       <= 33'd0;
      quo_r       <= 32'd0;
      divisor_r   <= 32'd0;
      quo_neg_r   <= 1'b0;
      rem_neg_r   <= 1'b0;
      op_r        <= 2'b00;
      res_r       <= 32'd0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else if (flush) begin
      state_r     <= ST_IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid && in_ready_r) begin
            op_r       <= div_op;
            divisor_r  <= abs_b_s;
            quo_neg_r  <= signed_op_s & (a_data[XLEN-1] ^ b_data[XLEN-1]);
            rem_neg_r  <= signed_op_s & a_data[XLEN-1];
            in_ready_r <= 1'b0;
            count_r    <= 6'd0;
            if (div_zero_s) begin
              res_r       <= div_op[1] ? a_data : 32'hFFFF_FFFF;
              out_valid_r <= 1'b1;
              state_r     <= ST_DONE;
            end else if (overflow_s) begin
              res_r       <= div_op[1] ? 32'd0 : 32'h8000_0000;
              out_valid_r <= 1'b1;
              state_r     <= ST_DONE;
            end else begin
              rem_r   <= 33'd0;
              quo_r   <= abs_a_s;
              state_r <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          rem_r   <= rem_next_s;
          quo_r   <= quo_next_s;
          count_r <= count_r + 6'd1;
          if (count_r == 6'(ITER_COUNT - 1)) begin
            state_r <= ST_FIX;
          end
        end
        ST_FIX: begin
          res_r       <= op_r[1] ? rem_fix_s[XLEN-1:0] : quo_fix_s;
          out_valid_r <= 1'b1;
          state_r     <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= ST_IDLE;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign div_res   = res_r;

endmodule

// File: tb/tb_iter_divider.sv
// Directed self-checking bench for iter_divider: results, latency, backpressure,
// mid-operation reset and flush.
module tb_iter_divider;
  import divider_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  div_op;
  logic [31:0] a_data;
  logic [31:0] b_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] div_res;

  int pass_cnt;
  int check_cnt;

  iter_divider #(.XLEN(32)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .div_op    (div_op),
    .a_data    (a_data),
    .b_data    (b_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .div_res   (div_res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    if (obs === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present one operation while idle; returns after the accepting edge (+1).
  task automatic accept_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    div_op   = op;
    a_data   = a;
    b_data   = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Count cycles until out_valid, starting right after the accepting edge.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_eq({tag, "_ovalid_drop"}, {31'd0, out_valid}, 32'd0);
    check_eq({tag, "_iready_back"}, {31'd0, in_ready}, 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat;
    check_eq({tag, "_iready"}, {31'd0, in_ready}, 32'd1);
    accept_op(op, a, b);
    wait_valid(lat);
    check_eq({tag, "_lat"}, lat, exp_lat);
    check_eq({tag, "_res"}, div_res, exp);
    release_result(tag);
  endtask

  initial begin
    int lat;
    logic [31:0] held;
    pass_cnt  = 0;
    check_cnt = 0;
    reset_n   = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    div_op    = 2'b00;
    a_data    = 32'd0;
    b_data    = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_iready", {31'd0, in_ready}, 32'd1);
    check_eq("rst_ovalid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_res", div_res, 32'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    run_op("divu_100_7",  DIV_OP_DIVU, 32'd100,        32'd7,          32'd14,         34);
    run_op("remu_100_7",  DIV_OP_REMU, 32'd100,        32'd7,          32'd2,          34);
    run_op("div_m7_2",    DIV_OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  34);
    run_op("rem_m7_2",    DIV_OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  34);
    run_op("rem_7_m2",    DIV_OP_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          34);
    run_op("div_20_m3",   DIV_OP_DIV,  32'd20,         32'hFFFF_FFFD,  32'hFFFF_FFFA,  34);
    run_op("div_min_2",   DIV_OP_DIV,  32'h8000_0000,  32'd2,          32'hC000_0000,  34);
    run_op("divu_max_1",  DIV_OP_DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  34);
    run_op("remu_max_16", DIV_OP_REMU, 32'hFFFF_FFFF,  32'd16,         32'd15,         34);
    run_op("divu_by0",    DIV_OP_DIVU, 32'd5,          32'd0,          32'hFFFF_FFFF,  1);
    run_op("rem_by0",     DIV_OP_REM,  32'h8000_0000,  32'd0,          32'h8000_0000,  1);
    run_op("div_ovf",     DIV_OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1);
    run_op("rem_ovf",     DIV_OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1);

    // Backpressure, with new operands waved at the busy unit during CALC.
    accept_op(DIV_OP_DIVU, 32'd1000, 32'd10);
    for (int i = 0; i < 6; i++) begin
      in_valid = i[0];
      div_op   = DIV_OP_REMU;
      a_data   = 32'd12345;
      b_data   = 32'd1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    wait_valid(lat);
    check_eq("bp_lat", lat, 34 - 6);
    check_eq("bp_res", div_res, 32'd100);
    held = div_res;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check_eq("bp_hold_res", div_res, held);
      check_eq("bp_hold_ovalid", {31'd0, out_valid}, 32'd1);
      check_eq("bp_hold_iready", {31'd0, in_ready}, 32'd0);
    end
    release_result("bp");

    // Reset at the 10th CALC cycle.
    accept_op(DIV_OP_DIVU, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    check_eq("mid_rst_iready", {31'd0, in_ready}, 32'd1);
    check_eq("mid_rst_ovalid", {31'd0, out_valid}, 32'd0);
    check_eq("mid_rst_res", div_res, 32'd0);
    repeat (40) begin
      @(posedge clk);
      #1;
      check_eq("mid_rst_quiet", {31'd0, out_valid}, 32'd0);
    end

    // Flush at the 10th CALC cycle, then a fresh operation.
    accept_op(DIV_OP_DIVU, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check_eq("flush_iready", {31'd0, in_ready}, 32'd1);
    check_eq("flush_ovalid", {31'd0, out_valid}, 32'd0);
    run_op("post_flush_divu_9_3", DIV_OP_DIVU, 32'd9, 32'd3, 32'd3, 34);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
